// File: rtl/vector_buf.sv
// Write-once, fill-in-order buffer: collects DATA_WID-bit words into one flat
// register, slot 0 first, and drops further input once every slot is written.
module vector_buf #(
  parameter int unsigned DATA_WID = 8,
  parameter int unsigned BUF_SIZE = 64,
  localparam int unsigned CNT_W   = $clog2(BUF_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WID-1:0]          dataIn,
  input  logic                         dataValid,
  output logic [BUF_SIZE*DATA_WID-1:0] buffer,
  output logic                         isFull,
  output logic [CNT_W-1:0]             fillCount
);

  logic [BUF_SIZE*DATA_WID-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         full;
  logic                         wr_en;

  assign full  = (cnt_q == CNT_W'(BUF_SIZE));
  assign wr_en = dataValid && !full;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      // Slot select by compare keeps the write index width-clean for any size.
      for (int unsigned i = 0; i < BUF_SIZE; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          buf_d[i*DATA_WID +: DATA_WID] = dataIn;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buffer    = buf_q;
  assign fillCount = cnt_q;
  assign isFull    = full;

endmodule

// File: tb/tb_vector_buf.sv
// Randomized and directed checks of vector_buf (default and 16x3 instances)
// against an array-based reference model of the fill rules.
module tb_vector_buf;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   din1 = '0;
  logic         dv1 = 1'b0;
  logic [511:0] buf1;
  logic         full1;
  logic [6:0]   cnt1;
  logic [15:0]  din2 = '0;
  logic         dv2 = 1'b0;
  logic [47:0]  buf2;
  logic         full2;
  logic [1:0]   cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m1 [64];
  int          m1n = 0;
  logic [15:0] m2 [3];
  int          m2n = 0;

  vector_buf u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .dataIn    (din1),
    .dataValid (dv1),
    .buffer    (buf1),
    .isFull    (full1),
    .fillCount (cnt1)
  );

  vector_buf #(.DATA_WID(16), .BUF_SIZE(3)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .dataIn    (din2),
    .dataValid (dv2),
    .buffer    (buf2),
    .isFull    (full2),
    .fillCount (cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_buf1();
    logic [511:0] e = '0;
    for (int i = 0; i < 64; i++) e[i*8 +: 8] = m1[i];
    return e;
  endfunction

  function automatic logic [511:0] exp_buf2();
    logic [511:0] e = '0;
    for (int i = 0; i < 3; i++) e[i*16 +: 16] = m2[i];
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m1[i] = '0;
    for (int i = 0; i < 3; i++)  m2[i] = '0;
    m1n = 0;
    m2n = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_buf1"},  512'(buf1),  exp_buf1());
    check({tag, "_cnt1"},  512'(cnt1),  512'(m1n));
    check({tag, "_full1"}, 512'(full1), 512'(m1n == 64));
    check({tag, "_buf2"},  512'(buf2),  exp_buf2());
    check({tag, "_cnt2"},  512'(cnt2),  512'(m2n));
    check({tag, "_full2"}, 512'(full2), 512'(m2n == 3));
  endtask

  // One clock cycle; called just after an edge, samples 1 time unit after the next.
  task automatic step(input string tag, input logic v1, input logic [7:0] d1,
                      input logic v2, input logic [15:0] d2);
    dv1 = v1; din1 = d1; dv2 = v2; din2 = d2;
    @(posedge clk);
    if (rst) begin
      if (v1 && m1n < 64) begin m1[m1n] = d1; m1n++; end
      if (v2 && m2n < 3)  begin m2[m2n] = d2; m2n++; end
    end
    #1;
    dv1 = 1'b0; dv2 = 1'b0;
    check_all(tag);
  endtask

  // Reset pulled low between edges with writes pending; held across one edge.
  task automatic async_reset(input string tag);
    dv1 = 1'b1; din1 = 8'($urandom);
    dv2 = 1'b1; din2 = 16'($urandom);
    #2 rst = 1'b0;
    model_clear();
    #1 check_all({tag, "_low"});
    @(posedge clk);
    #1 check_all({tag, "_hold"});
    rst = 1'b1;
    dv1 = 1'b0; dv2 = 1'b0;
  endtask

  initial begin
    logic [7:0] t2 [4];
    logic [7:0] t3d [5];
    logic       t3v [5];
    logic [15:0] t6 [4];
    t2  = '{8'h80, 8'h06, 8'h00, 8'h01};
    t3d = '{8'hAA, 8'h11, 8'hBB, 8'h22, 8'hCC};
    t3v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t6  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    model_clear();
    @(posedge clk);
    #1 check_all("por");
    rst = 1'b1;

    // 1: random prior contents, then asynchronous reset
    for (int i = 0; i < 7; i++) step("pre", 1'b1, 8'($urandom), 1'b1, 16'($urandom));
    async_reset("t1");
    step("t1_rel", 1'b0, 8'h00, 1'b0, 16'h0);

    // 2: consecutive setup-packet bytes
    for (int i = 0; i < 4; i++) step("t2", 1'b1, t2[i], 1'b0, 16'h0);
    check("t2_low32", 512'(buf1[31:0]), 512'(32'h01000680));
    check("t2_upper", 512'(buf1[511:32]), 512'(0));
    async_reset("t2r");

    // 3: gapped writes
    for (int i = 0; i < 5; i++) step("t3", t3v[i], t3d[i], 1'b0, 16'h0);
    check("t3_cnt", 512'(cnt1), 512'(3));
    check("t3_slots", 512'(buf1[23:0]), 512'(24'hCCBBAA));
    async_reset("t3r");

    // 4: fill completely, then overflow attempts
    for (int i = 0; i < 64; i++) begin
      check("t4_notfull", 512'(full1), 512'(0));
      step("t4", 1'b1, 8'(i), 1'b0, 16'h0);
    end
    check("t4_full", 512'(full1), 512'(1));
    check("t4_slot63", 512'(buf1[511:504]), 512'(8'd63));
    for (int i = 0; i < 5; i++) step("t4_ovf", 1'b1, 8'hFF, 1'b0, 16'h0);
    check("t4_cnt", 512'(cnt1), 512'(64));
    async_reset("t4r");

    // 5: mid-fill async reset, then a fresh write lands in slot 0
    for (int i = 0; i < 10; i++) step("t5", 1'b1, 8'($urandom), 1'b0, 16'h0);
    async_reset("t5r");
    step("t5_w", 1'b1, 8'h5A, 1'b0, 16'h0);
    check("t5_slot0", 512'(buf1), 512'(8'h5A));
    check("t5_cnt", 512'(cnt1), 512'(1));

    // 6: 16-bit x 3 instance overflow
    async_reset("t6r");
    for (int i = 0; i < 4; i++) step("t6", 1'b0, 8'h00, 1'b1, t6[i]);
    check("t6_buf", 512'(buf2), 512'(48'h9ABC_5678_1234));
    check("t6_full", 512'(full2), 512'(1));

    // Randomized rounds with occasional asynchronous resets
    for (int r = 0; r < 6; r++) begin
      async_reset("rnd_r");
      for (int c = 0; c < 90; c++) begin
        if ($urandom_range(0, 59) == 0) async_reset("rnd_ar");
        else step("rnd", $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
